mux81_rr_arbiter: RTL and testbench
===================================

Name: mux81_rr_arbiter

Overview:
- 8-requester round-robin arbiter that owns the select of the shared 8:1 single-bit mux.
- Grants one requester at a time and drives that requester's index on sel, so the winner's D input reaches out.
- Each grant is held until the requester releases or a hold timeout expires.
- On every ownership change, inserts one bubble cycle with no grant so the mux path settles before the next owner.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles before forced rotation when another requester is waiting. Legal range is 2 to 255.
- CNT_W, 8: width of the internal hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Asynchronous, active-high reset.
- req  input  8  req[i]=1 means requester i wants the mux. Held high for the whole transfer.
- gnt  output  8  One-hot grant, registered. All zeros when nobody owns the mux.
- sel  output  3  Mux select, registered. Equals the index of the set bit of gnt while gnt_valid=1.
- gnt_valid  output  1  High while some requester owns the mux, registered.
- preempt  output  1  One-cycle pulse, registered: current grant ended by timeout.

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE, gnt=8'h00, sel=3'd0, gnt_valid=0, preempt=0.
  - last_ptr=3'd7, so requester 0 has top priority after reset.
  - hold_cnt=0.
- Asserting rst mid-grant clears everything above asynchronously. No clean-up cycle is needed.
- Arbitration function: winner = first i with req[i]=1, searching last_ptr+1, last_ptr+2, ... modulo 8 (wraps 7->0). The search ends with last_ptr itself.
- States:
  - IDLE. At each edge, if req != 0: go to GRANT, load gnt=onehot(winner), sel=winner, gnt_valid=1, last_ptr=winner, hold_cnt=0. Otherwise stay in IDLE with all outputs at their reset values, except sel, which holds its last value.
  - GRANT. On each edge, evaluate in priority order:
    1. req[sel]=0 (release): go to GAP, gnt=0, gnt_valid=0, preempt=0.
    2. hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0 (timeout with a competitor): go to GAP, gnt=0, gnt_valid=0, preempt=1.
    3. hold_cnt==MAX_HOLD-1 and no competitor: stay in GRANT, hold_cnt=0. No preempt, no bubble.
    4. Otherwise: hold_cnt=hold_cnt+1.
  - GAP. Lasts exactly one cycle; preempt is cleared. sel holds the previous owner's index. Arbitration here is identical to IDLE: if req!=0 go to GRANT with the new winner, else go to IDLE.
- Timing:
  - Grant latency from IDLE: req sampled at edge N gives gnt/sel valid after edge N.
  - Handover: release sampled at edge N puts GAP after edge N and the new grant after edge N+1. This is exactly one bubble cycle.
- Fairness:
  - A preempted requester still holding req is searched last.
  - Any requester waits at most 7 × (MAX_HOLD+1) cycles.
- gnt never has more than one bit set. gnt_valid=1 if and only if gnt!=0.
- Requests rising during GRANT do not affect the current owner until release or timeout.
- A requester that drops req in the same cycle it would be granted is not granted, because req is sampled at the edge.

Test Plan:
1. Reset with req=8'h00, then req=8'h01 → one edge later gnt=8'h01, sel=0, gnt_valid=1. Assert rst mid-grant → all outputs zero immediately, without waiting for a clock.
2. req=8'hFF held, each requester dropping its req after 3 grant cycles → grant order 0,1,2,...,7,0, with exactly one gnt=0 cycle between grants.
3. req=8'h81, last_ptr=7 after reset → 0 wins. After 0 releases, 7 wins. Confirms the 7→0 wrap and the pointer update.
4. MAX_HOLD=16, req[2] held forever, req[5] asserted at grant cycle 3 → after 16 grant cycles preempt=1 and gnt=0 for one cycle, then gnt=8'h20 and sel=5. Owner 2 is re-granted only after 5 releases or times out.
5. req[4] alone held for 40 cycles → gnt=8'h10 continuously, no bubble, preempt never asserted. The hold counter wraps silently.
6. Release of the owner coincident with a new req arriving → GAP, then the correct round-robin winner. Random req for 10k cycles with assertions: gnt one-hot or zero, sel matches gnt, no grant to a requester whose req=0.

Source files
------------

// File: rtl/mux81_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the round-robin
// arbiter that drives the shared 8:1 mux select.
interface mux81_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       preempt;

  modport master (output req, input gnt, sel, gnt_valid, preempt);
  modport slave  (input req, output gnt, sel, gnt_valid, preempt);
endinterface

// File: rtl/mux81_rr_arbiter.sv
// 8-requester round-robin arbiter owning the select of a shared 8:1 mux.
// Grants are held until release or timeout; every ownership change costs one bubble.
module mux81_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux81_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_d;
  logic [7:0]       gnt, gnt_d;
  logic [2:0]       sel, sel_d;
  logic             gnt_valid, gnt_valid_d;
  logic             preempt, preempt_d;
  logic [2:0]       last_ptr, last_ptr_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;

  logic [2:0] win;
  logic [2:0] cand;
  logic       win_found;
  logic       at_max;
  logic       competitor;
  logic       released;

  // Search starts just after the last owner and ends on the last owner itself.
  always_comb begin
    win       = last_ptr;
    win_found = 1'b0;
    cand      = last_ptr;
    for (int i = 1; i <= 8; i++) begin
      cand = last_ptr + 3'(i);
      if (!win_found && bus.req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  assign at_max     = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign competitor = |(bus.req & ~gnt);
  assign released   = !bus.req[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 8'h00;
      sel       <= 3'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      last_ptr  <= 3'd7;
      hold_cnt  <= '0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      sel       <= sel_d;
      gnt_valid <= gnt_valid_d;
      preempt   <= preempt_d;
      last_ptr  <= last_ptr_d;
      hold_cnt  <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, GAP: state_d = win_found ? GRANT : IDLE;
      GRANT:     if (released || (at_max && competitor)) state_d = GAP;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt;
    sel_d       = sel;
    gnt_valid_d = gnt_valid;
    preempt_d   = 1'b0;
    last_ptr_d  = last_ptr;
    hold_cnt_d  = hold_cnt;
    case (state)
      IDLE, GAP: begin
        if (win_found) begin
          gnt_d       = 8'b1 << win;
          sel_d       = win;
          gnt_valid_d = 1'b1;
          last_ptr_d  = win;
          hold_cnt_d  = '0;
        end else begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (released) begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
        end else if (at_max && competitor) begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          preempt_d   = 1'b1;
        end else if (at_max) begin
          // Lone owner: restart the window silently, no bubble.
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt       = gnt;
  assign bus.sel       = sel;
  assign bus.gnt_valid = gnt_valid;
  assign bus.preempt   = preempt;

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Directed + random bench for mux81_rr_arbiter; a scoreboard queue holds the
// expected owner sequence and is drained whenever a new grant appears.
module tb_mux81_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   sb[$];
  logic [7:0] prev_gnt = 8'h00;
  logic [7:0] req_edge;

  mux81_rr_arbiter_if bus();

  mux81_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard drain: each newly appearing owner must match the next expected index.
  always @(negedge clk) begin
    if (mon_en && bus.gnt_valid && bus.gnt !== prev_gnt) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", bus.sel);
      end
      if (sb.size() != 0) chk("sb_owner", {29'd0, bus.sel}, sb.pop_front());
    end
    prev_gnt <= bus.gnt;
  end

  initial begin
    bus.req = 8'h00;
    mon_en  = 1'b1;

    // 1: reset values, first grant latency, async reset mid-grant
    do_reset();
    chk("rst_gnt", bus.gnt, 8'h00);
    chk("rst_sel", bus.sel, 3'd0);
    chk("rst_valid", bus.gnt_valid, 1'b0);
    chk("rst_preempt", bus.preempt, 1'b0);
    sb.push_back(0);
    bus.req = 8'h01;
    tick();
    chk("t1_gnt", bus.gnt, 8'h01);
    chk("t1_sel", bus.sel, 3'd0);
    chk("t1_valid", bus.gnt_valid, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t1_async_gnt", bus.gnt, 8'h00);
    chk("t1_async_valid", bus.gnt_valid, 1'b0);
    chk("t1_async_sel", bus.sel, 3'd0);
    bus.req = 8'h00;
    tick();
    rst = 1'b0;
    tick();

    // 2: all requesting, each owner releases after 3 cycles -> 0..7,0
    for (int k = 0; k < 8; k++) sb.push_back(k);
    sb.push_back(0);
    bus.req = 8'hFF;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("t2_owner", bus.gnt, 32'(8'b1 << k));
      tick();
      tick();
      bus.req[k] = 1'b0;
      if (k == 7) bus.req[0] = 1'b1;
      tick();
      chk("t2_bubble", {bus.gnt_valid, bus.gnt}, 9'h000);
      tick();
    end
    chk("t2_wrap", bus.gnt, 8'h01);
    bus.req = 8'h00;
    tick();
    tick();

    // 3: 7->0 wrap from reset pointer, then pointer moves on to 7
    do_reset();
    sb.push_back(0);
    sb.push_back(7);
    bus.req = 8'h81;
    tick();
    chk("t3_first", bus.gnt, 8'h01);
    tick();
    bus.req = 8'h80;
    tick();
    chk("t3_gap", bus.gnt, 8'h00);
    tick();
    chk("t3_second", bus.gnt, 8'h80);
    chk("t3_sel", bus.sel, 3'd7);
    bus.req = 8'h00;
    tick();
    tick();

    // 4: timeout with competitor -> preempt, bubble, handover, then back to 2
    do_reset();
    sb.push_back(2);
    sb.push_back(5);
    sb.push_back(2);
    bus.req = 8'h04;
    tick();
    chk("t4_grant", bus.gnt, 8'h04);
    tick();
    tick();
    bus.req = 8'h24;
    for (int c = 4; c <= 16; c++) begin
      tick();
      chk("t4_hold", {bus.preempt, bus.gnt}, 9'h004);
    end
    tick();
    chk("t4_preempt", bus.preempt, 1'b1);
    chk("t4_gap", {bus.gnt_valid, bus.gnt}, 9'h000);
    chk("t4_gap_sel", bus.sel, 3'd2);
    tick();
    chk("t4_new_gnt", bus.gnt, 8'h20);
    chk("t4_new_sel", bus.sel, 3'd5);
    chk("t4_pre_clr", bus.preempt, 1'b0);
    tick();
    tick();
    chk("t4_5_holds", bus.gnt, 8'h20);
    bus.req = 8'h04;
    tick();
    chk("t4_rel_gap", {bus.preempt, bus.gnt}, 9'h000);
    tick();
    chk("t4_back2", bus.gnt, 8'h04);
    bus.req = 8'h00;
    tick();
    tick();

    // 5: lone requester holds past MAX_HOLD with no bubble and no preempt
    sb.push_back(4);
    bus.req = 8'h10;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("t5_hold", {bus.preempt, bus.gnt_valid, bus.gnt}, 10'h110);
    end
    bus.req = 8'h00;
    tick();
    tick();

    // 6: release coincident with new requests -> bubble then next in order
    sb.push_back(1);
    sb.push_back(3);
    bus.req = 8'h02;
    tick();
    chk("t6_first", bus.gnt, 8'h02);
    tick();
    bus.req = 8'h09;
    tick();
    chk("t6_gap", bus.gnt, 8'h00);
    tick();
    chk("t6_next", bus.gnt, 8'h08);
    chk("t6_sel", bus.sel, 3'd3);
    bus.req = 8'h00;
    tick();
    tick();
    chk("sb_drained", sb.size(), 0);

    // Random traffic with structural invariants
    mon_en = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(3) == 0) bus.req = 8'($urandom);
      req_edge = bus.req;
      tick();
      chk("rnd_onehot", $onehot0(bus.gnt), 1'b1);
      chk("rnd_valid", bus.gnt_valid, |bus.gnt);
      if (bus.gnt_valid) chk("rnd_sel", bus.gnt, 32'(8'b1 << bus.sel));
      chk("rnd_noreq", bus.gnt & ~req_edge, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
